spi_write_arbiter: RTL and testbench
====================================

// Module: spi_write_arbiter
// PURPOSE
//  Shares the two SPI write engines (ADF4002 = dev 0, LMX2594 = dev 1) among N_REQ requesters:
//  the init sequencer, the UART debug decoder and the SPI-listener handler.
//  Round-robin grant; one transfer in flight at a time.
//  Drives the SPI master start/ready handshake and reports completion and timeout per transfer.
// PARAMETERS
//  N_REQ      3        number of requesters; index 0..N_REQ-1
//  DATA_W     24       SPI word width; also the value loaded on spi_data_depth
//  TIMEOUT    4096     max cycles from entering LAUNCH to done before abort
// PORTS
//  clk              in   1             system clock
//  rst_n            in   1             reset, synchronous, active-low
//  req_valid        in   N_REQ         requester i has a write pending
//  req_dev          in   N_REQ         target device per requester (0=ADF4002, 1=LMX2594)
//  req_data         in   N_REQ*DATA_W  word per requester; slice i = [i*DATA_W +: DATA_W]
//  req_ready        out  N_REQ         one-hot accept strobe (combinational)
//  spi_ready        in   2             SPI engine idle, per device
//  spi_start        out  2             one-cycle start pulse, per device
//  spi_dir          out  1             always 0 (write)
//  spi_data_tx      out  DATA_W        word to shift
//  spi_data_depth   out  8             bit count
//  done             out  1             one-cycle pulse at transfer end
//  done_id          out  2             requester index of finished transfer
//  done_err         out  1             qualifies done: 1 = ended by timeout
//  err_timeout      out  1             sticky timeout flag
//  err_clear        in   1             clears err_timeout
//  busy             out  1             state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - state=IDLE, rr_ptr=0; spi_start=0, spi_data_tx=0, spi_data_depth=0, spi_dir=0.
//    - done=0, done_err=0, done_id=0, err_timeout=0, timeout counter=0.
//    - An in-flight transfer is abandoned; no done is issued for it.
//  - Handshake: requester holds req_valid/req_dev/req_data stable until req_ready[i]=1 in that cycle.
//  - FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
//  - IDLE:
//    - If any req_valid: grant g = first set bit at or after rr_ptr (cyclic).
//    - req_ready[g]=1 in the same cycle; latch data, dev and g.
//    - rr_ptr <= (g+1) mod N_REQ; -> LAUNCH; timeout counter cleared.
//    - req_ready=0 in every other state and when no request is valid.
//  - LAUNCH: when spi_ready[dev]=1:
//    - spi_start[dev]<=1 for exactly one cycle; spi_data_tx<=data; spi_data_depth<=DATA_W.
//    - -> WAIT_ACK.
//  - WAIT_ACK: spi_ready[dev]=0 -> WAIT_DONE. The other device's ready is ignored.
//  - WAIT_DONE: spi_ready[dev]=1 -> done<=1, done_err<=0, done_id<=g; -> IDLE.
//  - Timeout:
//    - Counter increments every cycle in LAUNCH/WAIT_ACK/WAIT_DONE.
//    - When it reaches TIMEOUT-1 before normal completion: done<=1, done_err<=1, err_timeout<=1; -> IDLE.
//    - spi_start is never asserted after the abort.
//  - Latency:
//    - Grant to spi_start: 1 cycle if spi_ready is already high.
//    - Back-to-back: the next grant occurs in the cycle after done (IDLE); min 4 cycles per transfer.
//  - Simultaneous events:
//    - err_clear and a new timeout in the same cycle: set wins.
//    - Timeout and completion in the same cycle: completion wins (done_err=0).
//  - Fairness: a requester holding valid continuously is granted within N_REQ transfers.
//  - spi_data_tx/spi_data_depth hold their last launched value between transfers.
// STRUCTURE
//  - Shared package: FSM state encodings, DEV_ADF4002=0/DEV_LMX2594=1, default DATA_W and TIMEOUT.
//  - Sub-module rr_arbiter (N_REQ): inputs req, ptr; outputs one-hot grant + index, combinational.
//  - FSM, counter and datapath registers stay in spi_write_arbiter.
// TESTING (SPI engine model: ready drops 1 cycle after start, rises 30 cycles later)
//  1. Single request: req 0, dev 1, data 24'h00251C.
//     -> req_ready[0] same cycle; spi_start=2'b10 one cycle later, spi_data_tx=24'h00251C, depth=24.
//     -> done, done_id=0, done_err=0.
//  2. All three valid at once, ptr=0:
//     -> grant order 0,1,2, then 0 again if 0 is re-asserted; one spi_start pulse per grant; no overlap.
//  3. spi_ready[0] held 0 for 50 cycles before a dev-0 request:
//     -> stays in LAUNCH, spi_start=0; pulses the cycle after ready rises.
//  4. TIMEOUT=64, model never reasserts ready:
//     -> done with done_err=1 at cycle 64 after grant; err_timeout=1 until err_clear pulse; next request proceeds.
//  5. rst_n low in WAIT_DONE:
//     -> all outputs reset next edge, no done pulse; after release, a pending request is granted from ptr=0.
//  6. Dev-1 transfer with spi_ready[0] toggling throughout:
//     -> no effect on sequencing; completion tracks spi_ready[1] only.

Source files
------------

// File: rtl/spi_write_arbiter_pkg.sv
// Shared definitions for the SPI write arbiter: FSM encoding, device indices
// and default sizing.
package spi_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam logic DEV_ADF4002 = 1'b0;
  localparam logic DEV_LMX2594 = 1'b1;

  localparam int DEF_N_REQ   = 3;
  localparam int DEF_DATA_W  = 24;
  localparam int DEF_TIMEOUT = 4096;

endpackage

// File: rtl/spi_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// searching cyclically.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    logic found;
    int   c;
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      c = int'(ptr_i) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/spi_write_arbiter.sv
// Shares the ADF4002/LMX2594 SPI write engines among N_REQ requesters with a
// round-robin grant, one transfer in flight, and a per-transfer timeout.
module spi_write_arbiter
  import spi_write_arbiter_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_dev,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [1:0]              spi_ready,
  output logic [1:0]              spi_start,
  output logic                    spi_dir,
  output logic [DATA_W-1:0]       spi_data_tx,
  output logic [7:0]              spi_data_depth,
  output logic                    done,
  output logic [1:0]              done_id,
  output logic                    done_err,
  output logic                    err_timeout,
  input  logic                    err_clear,
  output logic                    busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       DEPTH    = 8'(DATA_W);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic               dev_q, dev_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [1:0]         start_q, start_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic [7:0]         depth_q, depth_d;
  logic               done_q, done_d;
  logic               done_err_q, done_err_d;
  logic [1:0]         done_id_q, done_id_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  data_q;

  logic [N_REQ-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any_req;
  logic               tmo_hit;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any_req)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign tmo_hit = (cnt_inc == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    dev_d      = dev_q;
    cnt_d      = cnt_q;
    start_d    = '0;
    tx_d       = tx_q;
    depth_d    = depth_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    done_id_d  = done_id_q;
    err_d      = err_clear ? 1'b0 : err_q;
    req_ready  = '0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          req_ready = gnt;
          gidx_d    = gnt_idx;
          dev_d     = req_dev[gnt_idx];
          ptr_d     = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          cnt_d     = '0;
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d = cnt_inc;
        // Abort beats a late ready so no start is ever issued after timeout
        if (tmo_hit) begin
          done_d     = 1'b1;
          done_err_d = 1'b1;
          done_id_d  = 2'(gidx_q);
          err_d      = 1'b1;
          state_d    = ST_IDLE;
        end else if (spi_ready[dev_q]) begin
          start_d[dev_q] = 1'b1;
          tx_d           = data_q;
          depth_d        = DEPTH;
          state_d        = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        cnt_d = cnt_inc;
        if (tmo_hit) begin
          done_d     = 1'b1;
          done_err_d = 1'b1;
          done_id_d  = 2'(gidx_q);
          err_d      = 1'b1;
          state_d    = ST_IDLE;
        end else if (!spi_ready[dev_q]) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_inc;
        // Completion wins over a coincident timeout
        if (spi_ready[dev_q]) begin
          done_d    = 1'b1;
          done_id_d = 2'(gidx_q);
          state_d   = ST_IDLE;
        end else if (tmo_hit) begin
          done_d     = 1'b1;
          done_err_d = 1'b1;
          done_id_d  = 2'(gidx_q);
          err_d      = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      dev_q      <= 1'b0;
      cnt_q      <= '0;
      start_q    <= '0;
      tx_q       <= '0;
      depth_q    <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      done_id_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      dev_q      <= dev_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      tx_q       <= tx_d;
      depth_q    <= depth_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      done_id_q  <= done_id_d;
      err_q      <= err_d;
    end
  end

  // Granted word is captured once; requester may change it after req_ready
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && any_req) begin
      data_q <= req_data[gnt_idx*DATA_W +: DATA_W];
    end
  end

  assign spi_start      = start_q;
  assign spi_dir        = 1'b0;
  assign spi_data_tx    = tx_q;
  assign spi_data_depth = depth_q;
  assign done           = done_q;
  assign done_id        = done_id_q;
  assign done_err       = done_err_q;
  assign err_timeout    = err_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_write_arbiter.sv
// Directed bench for spi_write_arbiter with a behavioural SPI engine model
// (ready drops one cycle after start and returns 30 cycles later).
module tb_spi_write_arbiter;

  localparam int N   = 3;
  localparam int DW  = 24;
  localparam int TMO = 64;
  localparam int LAT = 35;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_dev = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic [1:0]    spi_ready;
  logic [1:0]    spi_start;
  logic          spi_dir;
  logic [DW-1:0] spi_data_tx;
  logic [7:0]    spi_data_depth;
  logic          done;
  logic [1:0]    done_id;
  logic          done_err;
  logic          err_timeout;
  logic          err_clear = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  spi_write_arbiter #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_dev        (req_dev),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .spi_ready      (spi_ready),
    .spi_start      (spi_start),
    .spi_dir        (spi_dir),
    .spi_data_tx    (spi_data_tx),
    .spi_data_depth (spi_data_depth),
    .done           (done),
    .done_id        (done_id),
    .done_err       (done_err),
    .err_timeout    (err_timeout),
    .err_clear      (err_clear),
    .busy           (busy)
  );

  // SPI engine model
  logic [1:0] mdl_rdy = 2'b11;
  int         mdl_cnt [2] = '{0, 0};
  logic [1:0] lo = '0;
  logic [1:0] hang = '0;
  logic       tog_en = 1'b0;
  logic       tog_bit = 1'b0;
  int         n_start = 0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (spi_start[d]) begin
        mdl_cnt[d] <= 30;
        mdl_rdy[d] <= 1'b0;
      end else if (mdl_cnt[d] != 0) begin
        mdl_cnt[d] <= mdl_cnt[d] - 1;
      end else if (!hang[d]) begin
        mdl_rdy[d] <= 1'b1;
      end
    end
    n_start <= n_start + int'(spi_start[0]) + int'(spi_start[1]);
  end

  always @(negedge clk) if (tog_en) tog_bit <= ~tog_bit;

  assign spi_ready[0] = tog_en ? tog_bit : (mdl_rdy[0] & ~lo[0]);
  assign spi_ready[1] = mdl_rdy[1] & ~lo[1];

  typedef struct {
    logic [2:0]  vld;
    logic [2:0]  devs;
    logic [23:0] base;
    logic [2:0]  exp_rdy;
    int          exp_id;
  } vec_t;

  vec_t tbl [8];
  int   order [4] = '{0, 1, 2, 0};
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_req(input logic [2:0] vld, input logic [2:0] devs, input logic [23:0] base);
    req_valid = vld;
    req_dev   = devs;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base + 24'(i) * 24'h111111;
  endtask

  task automatic wait_done(input int n0, output int lat);
    bit got;
    got = 1'b0;
    lat = n0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      lat++;
      got = (done === 1'b1);
    end
    if (!got) chk("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          lat;
    logic        exp_dev;
    logic [23:0] exp_data;
    exp_dev  = v.devs[v.exp_id];
    exp_data = v.base + 24'(v.exp_id) * 24'h111111;
    @(negedge clk);
    set_req(v.vld, v.devs, v.base);
    #1;
    chk({nm, "_ready"}, 32'(req_ready), 32'(v.exp_rdy));
    @(negedge clk);
    req_valid = '0;
    chk({nm, "_start_n1"}, 32'(spi_start), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({nm, "_start"}, 32'(spi_start), exp_dev ? 32'd2 : 32'd1);
    chk({nm, "_tx"}, 32'(spi_data_tx), 32'(exp_data));
    chk({nm, "_depth"}, 32'(spi_data_depth), 32'd24);
    @(negedge clk);
    chk({nm, "_start_n3"}, 32'(spi_start), 32'd0);
    wait_done(3, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(LAT));
    chk({nm, "_done_id"}, 32'(done_id), 32'(v.exp_id));
    chk({nm, "_done_err"}, 32'(done_err), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   s0;
    logic seen;
    vec_t v;

    tbl[0] = '{3'b001, 3'b001, 24'h00251C, 3'b001, 0};
    tbl[1] = '{3'b111, 3'b010, 24'h123456, 3'b010, 1};
    tbl[2] = '{3'b111, 3'b101, 24'hABCDEF, 3'b100, 2};
    tbl[3] = '{3'b111, 3'b000, 24'h0F0F0F, 3'b001, 0};
    tbl[4] = '{3'b101, 3'b111, 24'h800001, 3'b100, 2};
    tbl[5] = '{3'b110, 3'b000, 24'h7FFFFE, 3'b010, 1};
    tbl[6] = '{3'b011, 3'b011, 24'h555555, 3'b001, 0};
    tbl[7] = '{3'b100, 3'b100, 24'hFFFFFF, 3'b100, 2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(spi_start), 32'd0);
    chk("rst_tx", 32'(spi_data_tx), 32'd0);
    chk("rst_depth", 32'(spi_data_depth), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_err", 32'(done_err), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_dir", 32'(spi_dir), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Table: round-robin pointer walk and single transfers
    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // All three valid at once from ptr 0, back-to-back grants
    @(negedge clk);
    s0 = n_start;
    set_req(3'b111, 3'b010, 24'h0A0B0C);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_grant%0d", k), 32'(req_ready), 32'd1 << order[k]);
      if (k > 0) chk($sformatf("t2_b2b%0d", k), 32'(done), 32'd1);
      @(negedge clk);
      req_valid[order[k]] = 1'b0;
      if (k == 2) req_valid[0] = 1'b1;
      wait_done(1, lat);
      #1;
    end
    chk("t2_starts", 32'(n_start - s0), 32'd4);
    chk("t2_idle_ready", 32'(req_ready), 32'd0);

    // Dev-0 ready held low: LAUNCH waits, start follows the rise
    @(negedge clk);
    lo[0] = 1'b1;
    set_req(3'b010, 3'b000, 24'h333333);
    #1;
    chk("t3_ready", 32'(req_ready), 32'b010);
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_hold%0d", i), {30'd0, spi_start}, 32'd0);
      @(negedge clk);
    end
    lo[0] = 1'b0;
    @(negedge clk);
    chk("t3_start", 32'(spi_start), 32'd1);
    chk("t3_tx", 32'(spi_data_tx), 32'h444444);
    wait_done(0, lat);
    chk("t3_done_id", 32'(done_id), 32'd1);
    chk("t3_done_err", 32'(done_err), 32'd0);

    // Timeout: engine never returns ready
    @(negedge clk);
    hang[1] = 1'b1;
    set_req(3'b100, 3'b100, 24'h444000);
    #1;
    chk("t4_ready", 32'(req_ready), 32'b100);
    @(negedge clk);
    req_valid = '0;
    wait_done(1, lat);
    chk("t4_lat", 32'(lat), 32'(TMO));
    chk("t4_done_err", 32'(done_err), 32'd1);
    chk("t4_done_id", 32'(done_id), 32'd2);
    chk("t4_err", 32'(err_timeout), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_nostart%0d", i), 32'(spi_start), 32'd0);
      chk($sformatf("t4_sticky%0d", i), 32'(err_timeout), 32'd1);
    end
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("t4_cleared", 32'(err_timeout), 32'd0);
    hang[1] = 1'b0;
    repeat (3) @(negedge clk);
    v = '{3'b001, 3'b001, 24'h5A5A5A, 3'b001, 0};
    run_vec(v, "t4_next");
    chk("t4_next_err", 32'(err_timeout), 32'd0);

    // Reset during WAIT_DONE, pointer left at 2 beforehand
    @(negedge clk);
    set_req(3'b010, 3'b000, 24'h600000);
    #1;
    chk("t5_ready", 32'(req_ready), 32'b010);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_start", 32'(spi_start), 32'd0);
    chk("t5_tx", 32'(spi_data_tx), 32'd0);
    chk("t5_depth", 32'(spi_data_depth), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_err", 32'(err_timeout), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("t5_no_done", 32'(seen), 32'd0);
    v = '{3'b111, 3'b000, 24'h0C0C0C, 3'b001, 0};
    run_vec(v, "t5_after");

    // Dev-1 transfer with dev-0 ready toggling
    tog_en = 1'b1;
    v = '{3'b001, 3'b001, 24'h00ABCD, 3'b001, 0};
    run_vec(v, "t6");
    tog_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
